// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: op encodings,
// per-op size/sign decode, FSM state type and the data-width legality check.
package lsu_pkg;

    typedef enum logic [3:0] {
        LB  = 4'h0,
        LBU = 4'h1,
        LH  = 4'h2,
        LHU = 4'h3,
        LW  = 4'h4,
        LWU = 4'h5,
        LD  = 4'h6,
        SB  = 4'h8,
        SH  = 4'h9,
        SW  = 4'hA,
        SD  = 4'hB
    } lsuOp_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} lsuState_t;

    // sizeLog is log2 of the access size in bytes; only64 marks ops that need a 64-bit bus.
    typedef struct packed {
        logic       known;
        logic       isStore;
        logic       signExt;
        logic       only64;
        logic [1:0] sizeLog;
    } opInfo_t;

    function automatic opInfo_t decodeOp(input logic [3:0] op);
        opInfo_t info;
        info = '0;
        info.known = 1'b1;
        case (op)
            LB:      begin info.signExt = 1'b1; info.sizeLog = 2'd0; end
            LBU:     begin info.sizeLog = 2'd0; end
            LH:      begin info.signExt = 1'b1; info.sizeLog = 2'd1; end
            LHU:     begin info.sizeLog = 2'd1; end
            LW:      begin info.signExt = 1'b1; info.sizeLog = 2'd2; end
            LWU:     begin info.only64 = 1'b1; info.sizeLog = 2'd2; end
            LD:      begin info.only64 = 1'b1; info.sizeLog = 2'd3; end
            SB:      begin info.isStore = 1'b1; info.sizeLog = 2'd0; end
            SH:      begin info.isStore = 1'b1; info.sizeLog = 2'd1; end
            SW:      begin info.isStore = 1'b1; info.sizeLog = 2'd2; end
            SD:      begin info.isStore = 1'b1; info.only64 = 1'b1; info.sizeLog = 2'd3; end
            default: info.known = 1'b0;
        endcase
        return info;
    endfunction

    function automatic bit dataWidthOk(input int w);
        return (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Load result alignment: shift the addressed lane down to bit 0, keep the
// access size and sign- or zero-extend to the full data width.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]           rdata,
    input  logic [$clog2(DATA_W/8)-1:0] lane,
    input  logic [1:0]                  sizeLog,
    input  logic                        signExt,
    output logic [DATA_W-1:0]           result
);
    localparam int LOG_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [6:0]        nBits;
    logic              signBit;

    // A full-width access shifts ONE out entirely, so the mask wraps to all ones.
    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        nBits   = 7'd8 << sizeLog;
        mask    = (ONE << nBits) - ONE;
        signBit = shifted[LOG_W'(nBits - 7'd1)];
        result  = (shifted & mask) | ((signExt && signBit) ? ~mask : '0);
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: width-generic byte enables, store replication,
// misalignment detection and a request/addr-ok/data-ok bus sequencer that
// holds the pipeline and cancels cleanly on flush.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [3:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                req_flush,
    output logic                stall,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                addr_err_load,
    output logic                addr_err_store,
    output logic [ADDR_W-1:0]   bad_vaddr,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata
);
    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = $clog2(BYTES);

    if (!dataWidthOk(DATA_W)) begin : gBadWidth
        $error("mem_lsu: DATA_W must be 32 or 64");
    end

    lsuState_t         state;
    logic [LANE_W-1:0] laneQ;
    logic [1:0]        sizeQ;
    logic              signQ;
    logic              storeQ;

    opInfo_t           reqInfo;
    logic [2:0]        sizeMask;
    logic              misaligned;
    logic              reqErr;
    logic              accept;
    logic [7:0]        beBase;
    logic [BYTES-1:0]  beNext;
    logic [DATA_W-1:0] wdataNext;
    logic [DATA_W-1:0] loadResult;

    assign reqInfo = decodeOp(req_op);

    // Classify the M-stage request: misaligned or width-illegal ops fault, clean ones are accepted.
    always_comb begin
        sizeMask   = 3'((4'd1 << reqInfo.sizeLog) - 4'd1);
        misaligned = (req_addr[2:0] & sizeMask) != 3'b000;
        reqErr     = (state == IDLE) && req_valid && reqInfo.known &&
                     (misaligned || (reqInfo.only64 && DATA_W != 64));
        accept     = (state == IDLE) && req_valid && reqInfo.known && !reqErr && !req_flush;
    end

    assign addr_err_load  = reqErr && !reqInfo.isStore;
    assign addr_err_store = reqErr && reqInfo.isStore;
    assign bad_vaddr      = reqErr ? req_addr : '0;

    // Byte enables: a size-wide run of ones placed at the addressed lane.
    always_comb begin
        case (reqInfo.sizeLog)
            2'd0:    beBase = 8'h01;
            2'd1:    beBase = 8'h03;
            2'd2:    beBase = 8'h0F;
            default: beBase = 8'hFF;
        endcase
        beNext = BYTES'(beBase) << req_addr[LANE_W-1:0];
    end

    // Each bus byte takes the store byte at the same offset within its size-wide slot.
    for (genvar gi = 0; gi < BYTES; gi++) begin : gLane
        assign wdataNext[8*gi +: 8] = req_wdata[8*(gi & int'(sizeMask)) +: 8];
    end

    // Sequencer; bus outputs are registered from the latched request and held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            laneQ     <= '0;
            sizeQ     <= '0;
            signQ     <= 1'b0;
            storeQ    <= 1'b0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_be    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        laneQ     <= req_addr[LANE_W-1:0];
                        sizeQ     <= reqInfo.sizeLog;
                        signQ     <= reqInfo.signExt;
                        storeQ    <= reqInfo.isStore;
                        bus_req   <= 1'b1;
                        bus_wr    <= reqInfo.isStore;
                        bus_be    <= beNext;
                        bus_addr  <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                        bus_wdata <= wdataNext;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // A data_ok seen here cannot belong to this request and is ignored.
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= req_flush ? DRAIN : WAIT;
                    end else if (req_flush) begin
                        bus_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                WAIT: begin
                    if (bus_data_ok) begin
                        state <= IDLE;
                    end else if (req_flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pipeline hold and completion pulse follow the state and the live handshake.
    always_comb begin
        stall      = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE:  stall = accept;
            REQ:   stall = 1'b1;
            WAIT: begin
                stall      = !bus_data_ok;
                resp_valid = bus_data_ok && !req_flush;
            end
            DRAIN: stall = req_valid;
            default: stall = 1'b0;
        endcase
    end

    lsu_load_align #(.DATA_W(DATA_W)) uAlign (
        .rdata   (bus_rdata),
        .lane    (laneQ),
        .sizeLog (sizeQ),
        .signExt (signQ),
        .result  (loadResult)
    );

    assign resp_rdata = (resp_valid && !storeQ) ? loadResult : '0;

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised load/store unit for the memory stage of the pipelined MIPS core. It replaces the fixed 32-bit combinational byte-enable and load-extend logic with a width-generic unit (32- or 64-bit data bus) that talks to memory over a request/address-ok/data-ok handshake. It holds the pipeline while a transfer is outstanding, flags misaligned addresses as exceptions, and cancels cleanly on pipeline flush.

## Interface
- ADDR_W, 32, virtual/physical address width
- DATA_W, 32, bus and register data width; legal values 32 or 64
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  M stage holds a load/store this cycle
- req_op  in  4  LSU op (package encoding: LB, LBU, LH, LHU, LW, LWU, LD, SB, SH, SW, SD)
- req_addr  in  ADDR_W  effective byte address
- req_wdata  in  DATA_W  store data, right-aligned
- req_flush  in  1  cancel the current M-stage instruction
- stall  out  1  freeze the pipeline at M and earlier stages
- resp_valid  out  1  one-cycle pulse; the transfer completed this cycle
- resp_rdata  out  DATA_W  aligned, sign- or zero-extended load result
- addr_err_load  out  1  misaligned load (AdEL)
- addr_err_store  out  1  misaligned store (AdES)
- bad_vaddr  out  ADDR_W  faulting address
- bus_req, bus_wr  out  1  request valid; write when 1
- bus_be  out  DATA_W/8  byte enables, which are meaningful for writes
- bus_addr  out  ADDR_W  address aligned to DATA_W/8 bytes
- bus_wdata  out  DATA_W  store data, replicated across lanes
- bus_addr_ok, bus_data_ok  in  1  request accepted; data or write-ack returned
- bus_rdata  in  DATA_W  read data

## Operation
- Access size: B=1, H=2, W=4, D=8 bytes. lane = addr[log2(DATA_W/8)-1:0]. be = ((1<<size)-1) << lane.
- LD, LWU and SD are legal only when DATA_W=64. If DATA_W=32, they raise the matching addr_err.
- Misalignment (addr mod size ≠ 0) while req_valid=1 in IDLE:
  - addr_err_* is driven combinationally and bad_vaddr=req_addr.
  - No bus request is issued, stall=0 and resp_valid=0.
- The store data for each size is replicated across all lanes of bus_wdata.
- Load result = (bus_rdata >> 8·lane_q) masked to size_q. It is sign-extended for LB/LH/LW and zero-extended for LBU/LHU/LWU. LD passes through unchanged.
- FSM states IDLE, REQ, WAIT, DRAIN:
  - IDLE: if req_valid, no error and no req_flush, latch op, lane, aligned address and wdata, then go to REQ. stall=1.
  - REQ: bus_req=1. On bus_addr_ok, go to WAIT. On req_flush without bus_addr_ok, go to IDLE. On req_flush with bus_addr_ok, go to DRAIN.
  - WAIT: on bus_data_ok, resp_valid=1, stall=0, then go to IDLE. On req_flush without bus_data_ok, go to DRAIN. On req_flush with bus_data_ok, go to IDLE with resp_valid suppressed.
  - DRAIN: bus_req=0. Discard the returning bus_data_ok, then go to IDLE. stall=req_valid, so new requests are held off.
- A store is committed once it is accepted by bus_addr_ok. The pipeline must assert req_flush for a store before that handshake.
- req_* inputs stay stable while stall=1. The unit uses the latched copies regardless.

## Timing
- Reset: state=IDLE. All outputs are 0: stall, resp_valid, bus_req, bus_wr, bus_be, bus_addr, bus_wdata, resp_rdata, the error flags and bad_vaddr.
- Reset during an operation returns to IDLE at once. The memory side shares rst, so no drain is needed.
- Minimum latency is 3 cycles: accept (IDLE) → REQ with addr_ok → WAIT with data_ok. resp_valid and the stall release happen in the data_ok cycle.
- bus_data_ok is never expected in the same cycle as its own bus_addr_ok. If it arrives in REQ, it is ignored.
- bus_* outputs are registered from the latched state and stay constant while bus_req=1 and bus_addr_ok=0.
- Back-to-back: a new request can be accepted in the cycle after resp_valid.

## Structure
- Package lsu_pkg: op encodings, size/sign decode function, state enum, and a DATA_W legality check (elaboration error for values other than 32 or 64).
- Sub-module lsu_load_align: combinational lane shift, mask and extend, parametrised by DATA_W. It is instantiated once.

## Test plan
- DATA_W=32, LW at 0x100, addr_ok in the first REQ cycle, data_ok one cycle later with 0xDEADBEEF → resp_rdata=0xDEADBEEF, stall high for exactly 2 cycles.
- LB at 0x103 with rdata 0x80FF_FFFF → 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x102 with wdata 0x1234 → bus_wr=1, be=4'b1100, bus_addr=0x100, bus_wdata=0x12341234.
- LW at 0x102 → addr_err_load=1, bad_vaddr=0x102, bus_req stays 0, stall=0.
- Flush in WAIT with data_ok delayed 3 cycles → DRAIN, no resp_valid, a new request is held off until data_ok, then accepted.
- DATA_W=64, LD at 0x8 → be=8'hFF, full 64-bit result. SW at 0x4 → be=8'hF0. LW at 0x4 returning 0xFFFF_FFFF_0000_0000 → 0xFFFF_FFFF_FFFF_FFFF.
